i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- Byte-level I2C target that consumes the bus driven by the I2C master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs, delivers written bytes on a valid/ready-style interface, and serves read bytes from a local data port.
- Sits between the shared open-drain bus and the target-side register/FIFO logic.

Parameters:
- SLAVE_ADDR, 7'h39, 7-bit bus address this target answers to.
- FILTER_LEN, 3, glitch-filter depth in clk cycles; used only when I2C_GLITCH_FILTER_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  bus clock from master.
- sda  inout  1  bus data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
- rx_ready  input  1  sink can accept a written byte.
- tx_data  input  8  byte to return on a master read.
- rx_data  output  8  last written byte.
- rx_valid  output  1  one-clk pulse; rx_data is valid.
- rx_overrun  output  1  one-clk pulse; a byte was NACKed because rx_ready was low.
- tx_ack  output  1  one-clk pulse; tx_data was latched, so the next byte may be presented.
- addressed  output  1  high from address ACK until STOP, repeated START or NACK.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high between START and STOP.

Behaviour:
- Reset values: sda released (z); rx_data=0, rx_valid=0, rx_overrun=0, tx_ack=0, addressed=0, rw=0, busy=0; state IDLE.
- Input synchronisation: scl and sda each pass through a 2-FF synchroniser, then one edge-detect register. Internal events lag the pins by 3 clk.
- Event definitions, all on synchronised signals:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bit timing:
  - Bits are shifted MSB first on scl_rise.
  - sda drive changes only on scl_fall, except STOP/START, which release immediately.
- State machine:
  - IDLE: on START -> ADDR, busy=1, bit count=0.
  - ADDR: shift 8 bits (7 address + R/W). At the scl_fall after bit 8:
    - address match -> drive sda low, rw<=bit0, addressed=1, go to ADDR_ACK.
    - mismatch -> WAIT_STOP, sda released.
  - ADDR_ACK: hold low through the 9th SCL high. At the next scl_fall:
    - rw=0 -> release sda, go to WR_DATA.
    - rw=1 -> latch tx_data, pulse tx_ack, drive bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits. At the scl_fall after bit 8:
    - rx_ready=1: rx_data<=byte, pulse rx_valid, drive ACK, go to WR_ACK.
    - rx_ready=0: release sda (NACK), pulse rx_overrun, go to WAIT_STOP with addressed=0.
  - WR_ACK: at scl_fall release sda, go to WR_DATA.
  - RD_DATA:
    - Drive a 0 bit low; release for a 1 bit.
    - After the 8th bit's scl_fall, release sda and go to RD_ACK.
  - RD_ACK: sample sda on scl_rise.
    - 0 (master ACK): at scl_fall latch tx_data, pulse tx_ack, drive bit7, go to RD_DATA.
    - 1 (master NACK): addressed=0, go to WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- Events that apply in any state:
  - START (repeated start included) -> ADDR, bit count cleared, addressed=0, sda released. START takes priority over any scl event in the same clk.
  - STOP -> IDLE, busy=0, addressed=0, sda released.
- General call (address 0) is not acknowledged.
- rx_valid, rx_overrun and tx_ack are never high for more than 1 clk per byte.
- rst_n asserted mid-transfer releases sda within the same cycle, because reset is asynchronous. After reset the block ignores bus activity until the next START.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised input passes through a FILTER_LEN-deep majority/stability filter. The filtered value changes only after FILTER_LEN consecutive equal samples.
  - Event latency becomes 3+FILTER_LEN clk.
  - Pulses shorter than FILTER_LEN clk are ignored.
- Not defined: no filter; latency is 3 clk.

Test Plan:
- Write 0x72 (addr 0x39, W), then data 0xA5 with rx_ready=1 -> sda low during both 9th clocks; one rx_valid pulse with rx_data=0xA5; busy falls after STOP.
- Read 0x73 with tx_data=0x3C, master ACK, then tx_data=0xC3 and master NACK -> bus carries 0x3C then 0xC3; two tx_ack pulses; addressed=0 after the NACK; sda released.
- Address 0x50 (W) -> sda never driven; addressed stays 0; rx_valid never pulses; WAIT_STOP until STOP.
- Write 0x72, data 0x11 with rx_ready=0 -> 9th bit released (NACK); one rx_overrun pulse; no rx_valid; subsequent bytes ignored until STOP.
- Write 0x72 then 0x55, repeated START, then read 0x73 -> rx_data=0x55; rw switches 0->1; address re-ACKed; bit count restarts cleanly.
- rst_n low during a read byte -> sda z immediately, all outputs at reset values; next full transaction succeeds. With I2C_GLITCH_FILTER_EN, a 1-clk SCL glitch shifts no bit.

Source files
------------

// File: rtl/i2c_slave_if.sv
// Target-side handshake of the I2C slave: written bytes out (valid, with overrun flag),
// read bytes in (tx_ack requests the next one), plus transaction status.
interface i2c_slave_if;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       tx_ack;
  logic       addressed;
  logic       rw;
  logic       busy;

  modport slave (
    input  rx_ready, tx_data,
    output rx_data, rx_valid, rx_overrun, tx_ack, addressed, rw, busy
  );

  modport master (
    output rx_ready, tx_data,
    input  rx_data, rx_valid, rx_overrun, tx_ack, addressed, rw, busy
  );
endinterface

// File: rtl/i2c_slave.sv
// Byte-level I2C target; optional SCL/SDA glitch filter under I2C_GLITCH_FILTER_EN.
// Bus events act 3 clk after the pins (3+FILTER_LEN filtered); rx_ready low NACKs the byte.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h39,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  state_e     state_q, state_d;
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_f, sda_f;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, tx_ack_q, tx_ack_d;
  logic       addressed_q, addressed_d, rw_q, rw_d, busy_q, busy_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda};
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic          scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = '0;
    if (scl_sync_q[1] != scl_filt_q) begin
      if (scl_cnt_q == CW'(FILTER_LEN - 1)) scl_filt_d = scl_sync_q[1];
      else                                  scl_cnt_d  = scl_cnt_q + 1'b1;
    end
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = '0;
    if (sda_sync_q[1] != sda_filt_q) begin
      if (sda_cnt_q == CW'(FILTER_LEN - 1)) sda_filt_d = sda_sync_q[1];
      else                                  sda_cnt_d  = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_ev, stop_ev, addr_hit, byte_done;
  always_comb begin
    scl_rise  = scl_f & ~scl_prev_q;
    scl_fall  = ~scl_f & scl_prev_q;
    start_ev  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    stop_ev   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    // Address 0 (general call) never matches, whatever SLAVE_ADDR is set to.
    addr_hit  = (shift_q[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);
    byte_done = scl_fall && (bit_cnt_q == 4'd8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_ev)     state_d = ADDR;
    else if (stop_ev) state_d = IDLE;
    else begin
      case (state_q)
        ADDR:     if (byte_done) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall)  state_d = rw_q ? RD_DATA : WR_DATA;
        WR_DATA:  if (byte_done) state_d = bus.rx_ready ? WR_ACK : WAIT_STOP;
        WR_ACK:   if (scl_fall)  state_d = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt_q == 4'd7) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_f) state_d = WAIT_STOP;
          else if (scl_fall)     state_d = RD_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_shift_d   = tx_shift_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_overrun_d = 1'b0;
    tx_ack_d     = 1'b0;
    addressed_d  = addressed_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    if (start_ev) begin
      busy_d      = 1'b1;
      bit_cnt_d   = 4'd0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_ev) begin
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == WR_DATA)) begin
        shift_d   = {shift_q[6:0], sda_f};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (byte_done) begin
          bit_cnt_d = 4'd0;
          if (addr_hit) begin
            sda_oe_d    = 1'b1;
            rw_d        = shift_q[0];
            addressed_d = 1'b1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            tx_shift_d = bus.tx_data[6:0];
            tx_ack_d   = 1'b1;
            sda_oe_d   = ~bus.tx_data[7];
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        WR_DATA: if (byte_done) begin
          bit_cnt_d = 4'd0;
          if (bus.rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
          end else begin
            sda_oe_d     = 1'b0;
            rx_overrun_d = 1'b1;
            addressed_d  = 1'b0;
          end
        end
        WR_ACK: if (scl_fall) sda_oe_d = 1'b0;
        // tx_shift_q[6] always holds the next bit to put on the bus.
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end else begin
            sda_oe_d   = ~tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_f) begin
            addressed_d = 1'b0;
          end else if (scl_fall) begin
            bit_cnt_d  = 4'd0;
            tx_shift_d = bus.tx_data[6:0];
            tx_ack_d   = 1'b1;
            sda_oe_d   = ~bus.tx_data[7];
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Sync stages reset to the idle-bus level so reset release never looks like an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      tx_shift_q   <= 7'd0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_ack_q     <= 1'b0;
      addressed_q  <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_f;
      sda_prev_q   <= sda_f;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_shift_q   <= tx_shift_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_ack_q     <= tx_ack_d;
      addressed_q  <= addressed_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
    end
  end

  assign sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.tx_ack     = tx_ack_q;
  assign bus.addressed  = addressed_q;
  assign bus.rw         = rw_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, pulse scoreboard plus bus-level checks.
module tb_i2c_slave;
  localparam int Q = 10;  // clk cycles per quarter SCL period
  localparam int K_RX = 0, K_OVR = 1, K_TX = 2;

  typedef struct {
    int         kind;
    logic [7:0] dat;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  wire  sda;
  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  i2c_slave_if bus_if ();
  i2c_slave dut (.clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .bus(bus_if));

  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] dat);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] dat);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected: got pulse kind %0d data 0x%02h, expected none", kind, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.dat !== dat) begin
        miscompares++;
        $display("FAIL sb_pulse: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                 kind, dat, e.kind, e.dat);
      end
    end
  endtask

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge clk) begin
    if (bus_if.rx_valid)   check_ev(K_RX, bus_if.rx_data);
    if (bus_if.rx_overrun) check_ev(K_OVR, 8'h00);
    if (bus_if.tx_ack)     check_ev(K_TX, 8'h00);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      scl = 1'b1; @(negedge clk);
      scl = 1'b0; repeat (Q - 4) @(negedge clk);
    end else begin
      wait_q();
    end
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    b     = sda;  wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && i == 4);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sda"}, 8'(sda), 8'h01);
    chk({tag, "_rx_data"}, bus_if.rx_data, 8'h00);
    chk({tag, "_pulses"}, {5'd0, bus_if.rx_valid, bus_if.rx_overrun, bus_if.tx_ack}, 8'h00);
    chk({tag, "_status"}, {5'd0, bus_if.addressed, bus_if.rw, bus_if.busy}, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    bus_if.rx_ready = 1'b1;
    bus_if.tx_data  = 8'h00;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_q();

    // Write 0x72 / 0xA5 with sink ready
    expect_ev(K_RX, 8'hA5);
    i2c_start();
    chk("wr_busy", 8'(bus_if.busy), 8'h01);
    send_byte(8'h72, 1'b0, ack);
    chk("wr_addr_ack", 8'(ack), 8'h00);
    chk("wr_addressed", 8'(bus_if.addressed), 8'h01);
    chk("wr_rw", 8'(bus_if.rw), 8'h00);
    send_byte(8'hA5, 1'b0, ack);
    chk("wr_data_ack", 8'(ack), 8'h00);
    chk("wr_rx_data", bus_if.rx_data, 8'hA5);
    i2c_stop();
    chk("wr_busy_after_stop", 8'(bus_if.busy), 8'h00);
    chk("wr_addressed_after_stop", 8'(bus_if.addressed), 8'h00);

    // Read 0x73: 0x3C with master ACK, 0xC3 with master NACK
    bus_if.tx_data = 8'h3C;
    expect_ev(K_TX, 8'h00);
    i2c_start();
    send_byte(8'h73, 1'b0, ack);
    chk("rd_addr_ack", 8'(ack), 8'h00);
    chk("rd_rw", 8'(bus_if.rw), 8'h01);
    recv_byte(d);
    chk("rd_byte0", d, 8'h3C);
    bus_if.tx_data = 8'hC3;
    expect_ev(K_TX, 8'h00);
    send_bit(1'b0, 1'b0);
    recv_byte(d);
    chk("rd_byte1", d, 8'hC3);
    send_bit(1'b1, 1'b0);
    chk("rd_addressed_after_nack", 8'(bus_if.addressed), 8'h00);
    chk("rd_sda_released", 8'(sda), 8'h01);
    i2c_stop();
    chk("rd_busy_after_stop", 8'(bus_if.busy), 8'h00);

    // Foreign address 0x50: never acknowledged, data ignored
    i2c_start();
    send_byte(8'hA0, 1'b0, ack);
    chk("foreign_addr_nack", 8'(ack), 8'h01);
    chk("foreign_addressed", 8'(bus_if.addressed), 8'h00);
    send_byte(8'h00, 1'b0, ack);
    chk("foreign_data_nack", 8'(ack), 8'h01);
    chk("foreign_busy", 8'(bus_if.busy), 8'h01);
    i2c_stop();
    chk("foreign_busy_after_stop", 8'(bus_if.busy), 8'h00);

    // General call is not acknowledged
    i2c_start();
    send_byte(8'h00, 1'b0, ack);
    chk("gencall_nack", 8'(ack), 8'h01);
    i2c_stop();

    // Write with sink not ready: NACK, overrun, rest of transfer ignored
    bus_if.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h72, 1'b0, ack);
    chk("ovr_addr_ack", 8'(ack), 8'h00);
    expect_ev(K_OVR, 8'h00);
    send_byte(8'h11, 1'b0, ack);
    chk("ovr_data_nack", 8'(ack), 8'h01);
    chk("ovr_addressed", 8'(bus_if.addressed), 8'h00);
    chk("ovr_rx_data_kept", bus_if.rx_data, 8'hA5);
    send_byte(8'h22, 1'b0, ack);
    chk("ovr_next_nack", 8'(ack), 8'h01);
    i2c_stop();
    bus_if.rx_ready = 1'b1;

    // Write 0x55, repeated START, read 0x96
    expect_ev(K_RX, 8'h55);
    i2c_start();
    send_byte(8'h72, 1'b0, ack);
    chk("rs_wr_rw", 8'(bus_if.rw), 8'h00);
    send_byte(8'h55, 1'b0, ack);
    chk("rs_wr_ack", 8'(ack), 8'h00);
    bus_if.tx_data = 8'h96;
    expect_ev(K_TX, 8'h00);
    i2c_start();
    chk("rs_addressed_cleared", 8'(bus_if.addressed), 8'h00);
    send_byte(8'h73, 1'b0, ack);
    chk("rs_rd_addr_ack", 8'(ack), 8'h00);
    chk("rs_rw", 8'(bus_if.rw), 8'h01);
    chk("rs_addressed", 8'(bus_if.addressed), 8'h01);
    recv_byte(d);
    chk("rs_rd_byte", d, 8'h96);
    send_bit(1'b1, 1'b0);
    i2c_stop();
    chk("rs_rx_data", bus_if.rx_data, 8'h55);

`ifdef I2C_GLITCH_FILTER_EN
    // A 1-clk SCL pulse inside a bit must not shift an extra bit
    i2c_start();
    send_byte(8'h72, 1'b1, ack);
    chk("glitch_addr_ack", 8'(ack), 8'h00);
    i2c_stop();
`endif

    // Reset asserted while the target drives a 0 data bit
    bus_if.tx_data = 8'h3C;
    expect_ev(K_TX, 8'h00);
    i2c_start();
    send_byte(8'h73, 1'b0, ack);
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    chk("mid_rd_sda_driven", 8'(sda), 8'h00);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    wait_q();
    @(negedge clk);
    rst_n = 1'b1;
    wait_q();

    // Full transaction after reset
    expect_ev(K_RX, 8'h5A);
    i2c_start();
    send_byte(8'h72, 1'b0, ack);
    chk("post_reset_addr_ack", 8'(ack), 8'h00);
    send_byte(8'h5A, 1'b0, ack);
    chk("post_reset_data_ack", 8'(ack), 8'h00);
    i2c_stop();
    chk("post_reset_rx_data", bus_if.rx_data, 8'h5A);

    wait_q();
    chk("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
